// File: rtl/memory_write_buffer_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : memory_write_buffer_scheduler
// Purpose  : Posted line write buffer between the memory arbiter and the
//            external memory port; reads bypass queued writes and hit in it.
// Revision : 1.0 - initial release
// ============================================================================
module memory_write_buffer_scheduler #(
    parameter int ADDR_WIDTH = 30,
    parameter int LINE_WIDTH = 128,
    parameter int DEPTH      = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_WIDTH-1:0]   reqAddr,
    input  logic                    reqEnable,
    input  logic                    reqIsWrite,
    input  logic [LINE_WIDTH-1:0]   reqWriteValue,
    output logic                    reqDone,
    output logic [LINE_WIDTH-1:0]   reqReadValue,
    output logic [ADDR_WIDTH-1:0]   memAddr,
    output logic                    memEnable,
    output logic                    memIsWrite,
    output logic [LINE_WIDTH-1:0]   memWriteValue,
    input  logic [LINE_WIDTH-1:0]   memReadValue,
    input  logic                    memDone,
    output logic                    bufferEmpty,
    output logic [$clog2(DEPTH):0]  bufferCount
);

    localparam int                c_PTR_W = $clog2(DEPTH);
    localparam int                c_CNT_W = c_PTR_W + 1;
    localparam logic [c_PTR_W:0]  c_FULL  = DEPTH[c_PTR_W:0];

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_READ  = 2'd1;
    localparam logic [1:0] c_ST_DRAIN = 2'd2;

    logic [1:0]             r_state;
    logic [1:0]             w_state_nxt;

    logic [DEPTH-1:0]       r_valid;
    logic [ADDR_WIDTH-1:0]  r_addr [DEPTH];
    logic [LINE_WIDTH-1:0]  r_data [DEPTH];
    logic [c_PTR_W-1:0]     r_head;
    logic [c_PTR_W-1:0]     r_tail;

    logic                   w_hit;
    logic [c_PTR_W-1:0]     w_hit_idx;
    logic                   w_sample;
    logic                   w_full;
    logic                   w_hit_draining;
    logic                   w_wr_merge;
    logic                   w_wr_enq;
    logic                   w_rd_hit;
    logic                   w_rd_miss;
    logic                   w_head_merge;
    logic                   w_start_read;
    logic                   w_start_drain;
    logic                   w_read_done;
    logic                   w_drain_done;
    logic [c_CNT_W-1:0]     w_count_nxt;

    // At most one valid entry can hold a given address, so the last match wins trivially.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_valid[i] && (r_addr[i] == reqAddr)) begin
                w_hit     = 1'b1;
                w_hit_idx = c_PTR_W'(i);
            end
        end
    end

    // The outstanding read miss owns the upstream port until its memDone.
    assign w_sample       = reqEnable && !reqDone && (r_state != c_ST_READ);
    assign w_full         = (bufferCount == c_FULL);
    assign w_hit_draining = (r_state == c_ST_DRAIN) && (w_hit_idx == r_head);

    always_comb begin
        w_wr_merge = 1'b0;
        w_wr_enq   = 1'b0;
        w_rd_hit   = 1'b0;
        w_rd_miss  = 1'b0;
        if (w_sample) begin
            if (reqIsWrite) begin
                if (w_hit && !w_hit_draining) begin
                    w_wr_merge = 1'b1;
                end else if (!w_hit && !w_full) begin
                    w_wr_enq = 1'b1;
                end
            end else if (w_hit) begin
                w_rd_hit = 1'b1;
            end else begin
                w_rd_miss = 1'b1;
            end
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: a pending read miss wins over draining
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_rd_miss) begin
                    w_state_nxt = c_ST_READ;
                end else if (bufferCount != '0) begin
                    w_state_nxt = c_ST_DRAIN;
                end
            end
            c_ST_READ: begin
                if (memDone) w_state_nxt = c_ST_IDLE;
            end
            c_ST_DRAIN: begin
                if (memDone) w_state_nxt = c_ST_IDLE;
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        w_start_read  = 1'b0;
        w_start_drain = 1'b0;
        w_read_done   = 1'b0;
        w_drain_done  = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                w_start_read  = w_rd_miss;
                w_start_drain = !w_rd_miss && (bufferCount != '0);
            end
            c_ST_READ:  w_read_done  = memDone;
            c_ST_DRAIN: w_drain_done = memDone;
            default: ;
        endcase
    end

    // A merge into the head in the same cycle the drain launches must reach memory.
    assign w_head_merge = w_wr_merge && (w_hit_idx == r_head);
    assign w_count_nxt  = bufferCount + c_CNT_W'(w_wr_enq) - c_CNT_W'(w_drain_done);
    assign bufferEmpty  = (bufferCount == '0) && (r_state != c_ST_DRAIN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid       <= '0;
            r_head        <= '0;
            r_tail        <= '0;
            bufferCount   <= '0;
            reqDone       <= 1'b0;
            reqReadValue  <= '0;
            memEnable     <= 1'b0;
            memIsWrite    <= 1'b0;
            memAddr       <= '0;
            memWriteValue <= '0;
        end else begin
            reqDone     <= w_wr_merge || w_wr_enq || w_rd_hit || w_read_done;
            bufferCount <= w_count_nxt;

            if (w_rd_hit) begin
                reqReadValue <= r_data[w_hit_idx];
            end else if (w_read_done) begin
                reqReadValue <= memReadValue;
            end

            if (w_wr_enq) begin
                r_valid[r_tail] <= 1'b1;
                r_tail          <= r_tail + c_PTR_W'(1);
            end
            if (w_drain_done) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + c_PTR_W'(1);
            end

            if (w_start_read) begin
                memEnable  <= 1'b1;
                memIsWrite <= 1'b0;
                memAddr    <= reqAddr;
            end else if (w_start_drain) begin
                memEnable     <= 1'b1;
                memIsWrite    <= 1'b1;
                memAddr       <= r_addr[r_head];
                memWriteValue <= w_head_merge ? reqWriteValue : r_data[r_head];
            end else if (w_read_done || w_drain_done) begin
                memEnable <= 1'b0;
            end
        end
    end

    // Entry payload needs no reset; validity gates every use of it.
    always_ff @(posedge clk) begin
        if (w_wr_enq) begin
            r_addr[r_tail] <= reqAddr;
            r_data[r_tail] <= reqWriteValue;
        end
        if (w_wr_merge) begin
            r_data[w_hit_idx] <= reqWriteValue;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_memory_write_buffer_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_memory_write_buffer_scheduler
// Purpose  : Self-checking bench: table vectors, directed corner sequences
//            and random traffic against a memory-coherence reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_memory_write_buffer_scheduler;

    logic         clk;
    logic         rst;
    logic [29:0]  reqAddr;
    logic         reqEnable;
    logic         reqIsWrite;
    logic [127:0] reqWriteValue;
    logic         reqDone;
    logic [127:0] reqReadValue;
    logic [29:0]  memAddr;
    logic         memEnable;
    logic         memIsWrite;
    logic [127:0] memWriteValue;
    logic [127:0] memReadValue;
    logic         memDone;
    logic         bufferEmpty;
    logic [2:0]   bufferCount;

    memory_write_buffer_scheduler #(
        .ADDR_WIDTH (30),
        .LINE_WIDTH (128),
        .DEPTH      (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .reqAddr       (reqAddr),
        .reqEnable     (reqEnable),
        .reqIsWrite    (reqIsWrite),
        .reqWriteValue (reqWriteValue),
        .reqDone       (reqDone),
        .reqReadValue  (reqReadValue),
        .memAddr       (memAddr),
        .memEnable     (memEnable),
        .memIsWrite    (memIsWrite),
        .memWriteValue (memWriteValue),
        .memReadValue  (memReadValue),
        .memDone       (memDone),
        .bufferEmpty   (bufferEmpty),
        .bufferCount   (bufferCount)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_chk  = 0;
    int n_pass = 0;

    // Memory model state
    logic [127:0] mem_img [logic [29:0]];
    logic [29:0]  log_a [$];
    logic [127:0] log_d [$];
    logic [29:0]  ev_a [$];
    logic         ev_w [$];
    int           mem_reads   = 0;
    int           mem_lat     = 0;
    int           resp_cnt    = 0;
    bit           rand_lat    = 1'b0;
    bit           mem_hold    = 1'b1;
    bit           inject_done = 1'b0;

    typedef struct {
        logic         isw;
        logic [29:0]  addr;
        logic [127:0] data;
        logic [127:0] exp_rd;
        int           exp_cnt;
    } vec_t;

    vec_t vecs [9];

    function automatic logic [127:0] init_val(input logic [29:0] a);
        return {2'b01, a, 2'b10, a, 2'b11, a, 2'b00, a};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Memory responder: completes a held request after mem_lat cycles unless held off.
    initial begin
        memDone      = 1'b0;
        memReadValue = '0;
        forever begin
            @(negedge clk);
            memDone = 1'b0;
            if (inject_done) begin
                memDone = 1'b1;
            end else if (rst || !memEnable) begin
                resp_cnt = 0;
            end else if (!mem_hold) begin
                if (resp_cnt >= mem_lat) begin
                    memDone  = 1'b1;
                    resp_cnt = 0;
                    ev_w.push_back(memIsWrite);
                    ev_a.push_back(memAddr);
                    if (memIsWrite) begin
                        mem_img[memAddr] = memWriteValue;
                        log_a.push_back(memAddr);
                        log_d.push_back(memWriteValue);
                    end else begin
                        if (mem_img.exists(memAddr)) memReadValue = mem_img[memAddr];
                        else memReadValue = init_val(memAddr);
                        mem_reads++;
                    end
                    if (rand_lat) mem_lat = int'($urandom_range(0, 3));
                end else begin
                    resp_cnt++;
                end
            end
        end
    end

    task automatic start_req(input logic isw, input logic [29:0] a, input logic [127:0] d);
        @(negedge clk);
        while (reqDone) @(negedge clk);
        reqEnable     = 1'b1;
        reqIsWrite    = isw;
        reqAddr       = a;
        reqWriteValue = d;
    endtask

    task automatic wait_done(output logic [127:0] rd, output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!reqDone && lat < 400);
        check("req_done_in_time", 128'(reqDone), 128'(1));
        rd = reqReadValue;
        @(negedge clk);
        reqEnable = 1'b0;
    endtask

    task automatic do_req(input logic isw, input logic [29:0] a, input logic [127:0] d,
                          output logic [127:0] rd, output int lat);
        start_req(isw, a, d);
        wait_done(rd, lat);
    endtask

    task automatic wait_empty(input string name);
        int k;
        k = 0;
        @(negedge clk);
        while (!(bufferEmpty && !memEnable) && k < 500) begin
            @(negedge clk);
            k++;
        end
        check(name, 128'(k < 500), 128'(1));
    endtask

    task automatic watch_stall(input int cycles, output logic seen);
        seen = 1'b0;
        repeat (cycles) begin
            @(posedge clk);
            #1;
            if (reqDone) seen = 1'b1;
        end
    endtask

    initial begin
        logic [127:0] rd;
        int           lat;
        logic         seen;
        logic [29:0]  exp_a [$];
        logic [127:0] exp_d [$];
        logic [127:0] ref_mem [8];
        bit           ref_valid [8];

        vecs[0] = '{1'b1, 30'h40, 128'hD0D0_0000, 128'h0,        1};
        vecs[1] = '{1'b1, 30'h41, 128'hD1D1_1111, 128'h0,        2};
        vecs[2] = '{1'b0, 30'h41, 128'h0,         128'hD1D1_1111, 2};
        vecs[3] = '{1'b1, 30'h41, 128'hD2D2_2222, 128'h0,        2};
        vecs[4] = '{1'b0, 30'h41, 128'h0,         128'hD2D2_2222, 2};
        vecs[5] = '{1'b0, 30'h40, 128'h0,         128'hD0D0_0000, 2};
        vecs[6] = '{1'b1, 30'h42, 128'hD3D3_3333, 128'h0,        3};
        vecs[7] = '{1'b1, 30'h43, 128'hD4D4_4444, 128'h0,        4};
        vecs[8] = '{1'b0, 30'h43, 128'h0,         128'hD4D4_4444, 4};

        rst           = 1'b1;
        reqEnable     = 1'b0;
        reqIsWrite    = 1'b0;
        reqAddr       = '0;
        reqWriteValue = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rst_reqDone",     128'(reqDone),     128'(0));
        check("rst_memEnable",   128'(memEnable),   128'(0));
        check("rst_bufferEmpty", 128'(bufferEmpty), 128'(1));
        check("rst_bufferCount", 128'(bufferCount), 128'(0));
        check("rst_memAddr",     128'(memAddr),     128'(0));

        // Table vectors with the memory stalled: writes post, reads hit.
        for (int i = 0; i < 9; i++) begin
            do_req(vecs[i].isw, vecs[i].addr, vecs[i].data, rd, lat);
            check($sformatf("vec%0d_latency", i), 128'(lat), 128'(1));
            check($sformatf("vec%0d_count", i), 128'(bufferCount), 128'(vecs[i].exp_cnt));
            if (!vecs[i].isw) check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
        end
        check("drain_memEnable",  128'(memEnable),  128'(1));
        check("drain_memIsWrite", 128'(memIsWrite), 128'(1));
        check("drain_memAddr",    128'(memAddr),    128'(30'h40));
        check("drain_memWdata",   memWriteValue,    128'hD0D0_0000);
        check("hits_no_mem_read", 128'(mem_reads),  128'(0));

        // Fifth write into a full buffer stalls until the first drain completes.
        start_req(1'b1, 30'h44, 128'hD5D5_5555);
        watch_stall(6, seen);
        check("full_stall", 128'(seen), 128'(0));
        mem_hold = 1'b0;
        wait_done(rd, lat);
        check("full_after_count", 128'(bufferCount), 128'(4));
        wait_empty("drain_all_empty");
        exp_a = '{30'h40, 30'h41, 30'h42, 30'h43, 30'h44};
        exp_d = '{128'hD0D0_0000, 128'hD2D2_2222, 128'hD3D3_3333, 128'hD4D4_4444, 128'hD5D5_5555};
        check("drain_log_size", 128'(log_a.size()), 128'(5));
        for (int i = 0; i < 5 && i < log_a.size(); i++) begin
            check($sformatf("drain_order%0d", i), 128'(log_a[i]), 128'(exp_a[i]));
            check($sformatf("drain_data%0d", i), log_d[i], exp_d[i]);
        end

        // Write to the entry being drained stalls, then enqueues afresh.
        log_a.delete();
        log_d.delete();
        mem_hold = 1'b1;
        do_req(1'b1, 30'h20, 128'hCCCC, rd, lat);
        lat = 0;
        while (!memEnable && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        start_req(1'b1, 30'h20, 128'hDDDD);
        watch_stall(3, seen);
        check("drain_hit_stall", 128'(seen), 128'(0));
        mem_hold = 1'b0;
        wait_done(rd, lat);
        check("drain_hit_new_entry", 128'(bufferCount), 128'(1));
        wait_empty("drain_hit_empty");
        check("drain_hit_log_size", 128'(log_a.size()), 128'(2));
        if (log_d.size() == 2) begin
            check("drain_hit_first",  log_d[0], 128'hCCCC);
            check("drain_hit_second", log_d[1], 128'hDDDD);
        end

        // Read miss pending during a drain goes ahead of the remaining entries.
        ev_a.delete();
        ev_w.delete();
        mem_hold = 1'b1;
        do_req(1'b1, 30'h60, 128'h6060, rd, lat);
        do_req(1'b1, 30'h61, 128'h6161, rd, lat);
        do_req(1'b1, 30'h62, 128'h6262, rd, lat);
        start_req(1'b0, 30'h300, 128'h0);
        watch_stall(2, seen);
        check("miss_waits", 128'(seen), 128'(0));
        mem_hold = 1'b0;
        wait_done(rd, lat);
        check("miss_rdata", rd, init_val(30'h300));
        wait_empty("miss_empty");
        exp_a = '{30'h60, 30'h300, 30'h61, 30'h62};
        check("miss_ev_size", 128'(ev_a.size()), 128'(4));
        for (int i = 0; i < 4 && i < ev_a.size(); i++) begin
            check($sformatf("miss_ev_addr%0d", i), 128'(ev_a[i]), 128'(exp_a[i]));
            check($sformatf("miss_ev_wr%0d", i), 128'(ev_w[i]), 128'(i != 1));
        end

        // Reset in the middle of a drain with three entries queued.
        mem_hold = 1'b1;
        do_req(1'b1, 30'h70, 128'h7070, rd, lat);
        do_req(1'b1, 30'h71, 128'h7171, rd, lat);
        do_req(1'b1, 30'h72, 128'h7272, rd, lat);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mrst_count",   128'(bufferCount),   128'(0));
        check("mrst_empty",   128'(bufferEmpty),   128'(1));
        check("mrst_memEn",   128'(memEnable),     128'(0));
        check("mrst_memWr",   128'(memIsWrite),    128'(0));
        check("mrst_memAddr", 128'(memAddr),       128'(0));
        check("mrst_memData", memWriteValue,       128'(0));
        check("mrst_rdval",   reqReadValue,        128'(0));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        inject_done = 1'b1;
        @(negedge clk);
        inject_done = 1'b0;
        repeat (3) @(negedge clk);
        check("late_done_count", 128'(bufferCount), 128'(0));
        check("late_done_memEn", 128'(memEnable),   128'(0));
        check("late_done_empty", 128'(bufferEmpty), 128'(1));
        check("late_done_reqDn", 128'(reqDone),     128'(0));

        // Random traffic: every read must see the latest write to its line.
        mem_hold = 1'b0;
        rand_lat = 1'b1;
        for (int i = 0; i < 8; i++) ref_valid[i] = 1'b0;
        for (int n = 0; n < 300; n++) begin
            int           idx;
            logic         w;
            logic [127:0] d;
            idx = int'($urandom_range(0, 7));
            w   = ($urandom_range(0, 9) < 6);
            d   = {$urandom, $urandom, $urandom, $urandom};
            do_req(w, 30'h80 + 30'(idx), d, rd, lat);
            if (w) begin
                ref_mem[idx]   = d;
                ref_valid[idx] = 1'b1;
            end else begin
                check($sformatf("rand_read%0d", n), rd,
                      ref_valid[idx] ? ref_mem[idx] : init_val(30'h80 + 30'(idx)));
            end
            check("rand_count_bound", 128'(bufferCount <= 3'd4), 128'(1));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        wait_empty("rand_empty");
        for (int i = 0; i < 8; i++) begin
            if (ref_valid[i]) begin
                check($sformatf("rand_final%0d", i),
                      mem_img.exists(30'h80 + 30'(i)) ? mem_img[30'h80 + 30'(i)] : 128'(0),
                      ref_mem[i]);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/memory_write_buffer_scheduler.md
Name: memory_write_buffer_scheduler

Overview:
- Sits between the shared memory access arbiter and the external line-wide memory port.
- Absorbs line write-backs into a small posted write buffer and returns completion immediately, so read misses (I-fetch/D-cache refills) reach memory first.
- Drains buffered writes when the memory is otherwise idle and forwards read data from the buffer on an address hit.
- One upstream requester (the arbiter) and one downstream memory port; both follow the codebase's enable/done handshake.

Parameters:
- AddrWidth, 30, line address width.
- LineWidth, 128, line data width in bits.
- Depth, 4, write buffer entries (power of 2, >=2).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- reqAddr  in  AddrWidth  upstream line address
- reqEnable  in  1  upstream request valid, held until reqDone
- reqIsWrite  in  1  1=write, 0=read
- reqWriteValue  in  LineWidth  upstream write data
- reqDone  out  1  one-cycle completion pulse
- reqReadValue  out  LineWidth  read data, valid while reqDone=1 for reads
- memAddr  out  AddrWidth  memory line address
- memEnable  out  1  memory request, held until memDone
- memIsWrite  out  1  memory write flag
- memWriteValue  out  LineWidth  memory write data
- memReadValue  in  LineWidth  memory read data, valid with memDone
- memDone  in  1  one-cycle memory completion pulse
- bufferEmpty  out  1  no valid entries and no drain in flight (fence/flush status)
- bufferCount  out  $clog2(Depth)+1  number of valid entries

Behaviour:
- Reset: all entries invalid, head/tail = 0, state IDLE.
  - reqDone=0, reqReadValue=0, memEnable=0, memIsWrite=0, memAddr=0, memWriteValue=0, bufferEmpty=1, bufferCount=0.
  - Reset mid-operation discards buffered writes and any in-flight transaction. memDone arriving after reset is ignored.
- Outputs: all outputs registered; bufferEmpty and bufferCount are derived from registered state.
- Upstream handshake:
  - The request is sampled when reqEnable=1 and reqDone=0. reqEnable is ignored in the cycle reqDone=1.
  - Exactly one reqDone pulse per request.
- Write handling, decided in the sample cycle t:
  - Address matches a valid entry that is not currently draining: overwrite its data in place, keeping FIFO position. reqDone at t+1.
  - No match and buffer not full: enqueue at tail. reqDone at t+1.
  - Buffer full, or address matches the entry currently draining: stall, keep re-evaluating each cycle. No merge into in-flight data.
- Read handling:
  - Hit on any valid entry, including the draining one: reqReadValue = entry data, reqDone at t+1, no memory access.
  - Miss: when the FSM is IDLE, issue a memory read.
- Downstream FSM states: IDLE, READ, DRAIN.
  - IDLE -> READ when an upstream read miss is pending. Read has priority over drain.
    - memEnable=1, memIsWrite=0, memAddr=reqAddr from the next cycle.
  - IDLE -> DRAIN when the buffer is non-empty and no read miss is pending.
    - Head entry presented: memEnable=1, memIsWrite=1, memAddr/memWriteValue=head.
  - READ -> IDLE on memDone.
    - memReadValue is captured into reqReadValue; reqDone=1 next cycle; memEnable drops the cycle after memDone.
  - DRAIN -> IDLE on memDone.
    - Head entry is invalidated and head advances (wrap mod Depth); bufferCount decrements that same edge.
  - memAddr/memIsWrite/memWriteValue are stable for the whole memEnable period. No transaction is ever aborted.
- Simultaneous events:
  - Enqueue and drain-complete in the same cycle: count unchanged; the full check uses the pre-edge count, so a full buffer stalls one extra cycle.
  - A read miss arriving during DRAIN waits for memDone, then READ starts the next IDLE cycle.
  - A read hit needs no memory access, so it completes at t+1 even while DRAIN is in progress.
- Ordering: writes drain oldest-first. Per address at most one entry exists, so memory sees the final value of a merged write.
- Pointers wrap modulo Depth. Full means count==Depth; empty means count==0.

Test Plan:
- Write 0x100 data A (buffer empty, memory stalled memDone=0) -> reqDone at t+1; bufferCount=1; DRAIN starts next cycle with memAddr=0x100, memIsWrite=1, memWriteValue=A, held until memDone.
- Write 0x200=B, then read 0x200 before drain completes -> second reqDone at t+1 with reqReadValue=B; no memory read issued.
- Four writes 0x10..0x13 with memDone withheld, then fifth write 0x14 -> fifth stalls (reqDone=0) until first drain memDone; reqDone follows; drained order 0x10,0x11,0x12,0x13,0x14.
- Buffer holds 0x20=C (buffer idle, nothing draining); write 0x20=D -> merge, count stays 1; memory later sees only one write, value D. Variant: write 0x20=D while 0x20 is draining -> write stalls until that drain's memDone, then enqueues as a new entry.
- Buffer holds 2 entries; read miss 0x300 arrives in the cycle before DRAIN would start -> READ issued first; memReadValue=E at memDone -> reqDone+E next cycle, then drains resume.
- Assert rst mid-DRAIN with 3 entries -> all outputs zero next cycle, bufferEmpty=1; a late memDone causes no state change.
